regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the CPU integer register file. It has a configurable data width, register count and number of read ports. It adds write-to-read bypass, a synchronous reset, a hardwired trigger-mirror register and a per-register busy scoreboard, so the pipelined core can detect RAW/WAW hazards on in-flight writes. It sits between decode (read, reserve) and writeback (write, release), and exports a full register dump for the display/test harness.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, ≥4); AW = log2(NREGS)
- NRD, 2, number of combinational read ports
- TRIG_IDX, 31, index of register mirroring `trigger`; 0 disables the mirror
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy-clear forwarded to hazard flags

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- trigger  in  1  external trigger level, mirrored into register TRIG_IDX
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has an outstanding reservation
- we  in  1  writeback enable
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- rsv_en  in  1  decode reserves a destination register
- rsv_addr  in  AW  register to reserve
- rsv_ok  out  1  reservation accepted this cycle; 0 = WAW stall
- busy_vec  out  NREGS  scoreboard state
- dump  out  NREGS*XLEN  all register contents; register r at [r*XLEN +: XLEN]

## Operation
- Protected indices: 0 always, plus TRIG_IDX when TRIG_IDX≠0.
- Register 0 always reads 0 and is never written or reserved.
- Mirror register, when TRIG_IDX≠0:
  - Loads {XLEN-1 zeros, trigger} every clock edge.
  - Writebacks to it are dropped.
  - Never busy.
- Write: when we=1 and wr_addr is not protected, reg[wr_addr] ← wr_data at the edge. The write also clears busy[wr_addr].
- Read port i is combinational:
  - rd_data_i = reg[rd_addr_i].
  - If BYPASS=1, we=1, wr_addr=rd_addr_i and the address is not protected, rd_data_i = wr_data instead.
- rd_busy_i:
  - Equals busy[rd_addr_i].
  - If BYPASS=1, a same-cycle write to the same unprotected address forces it to 0.
- Reservation acceptance:
  - rsv_ok = 1 if rsv_addr is protected (no-op accept).
  - Otherwise rsv_ok = !busy[rsv_addr] OR (we=1 and wr_addr=rsv_addr). The writeback releases the register in the same cycle.
  - rsv_ok is combinational and independent of rsv_en.
- Scoreboard update: busy_next = (busy & ~clr) | set.
  - clr = one-hot of wr_addr when we=1.
  - set = one-hot of rsv_addr when rsv_en=1, rsv_ok=1 and the address is not protected.
  - Set wins over clear on the same address.
  - Rejected reservations leave busy unchanged.
- Writing a non-busy register is legal: data updates and busy stays 0.
- dump is the registered contents, no bypass. Register 0 is shown as 0.

## Timing
- Reset (rst_n=0 at an edge):
  - All registers, including the mirror, become 0 and busy_vec becomes 0.
  - While rst_n=0, we and rsv_en are ignored.
  - rsv_ok still evaluates combinationally against the current busy state.
- After reset: rd_data = 0, rd_busy = 0, rsv_ok = 1, dump = 0.
- Read latency 0 cycles. Write is visible in dump and in non-bypassed reads 1 cycle after the edge.
- Trigger-to-mirror latency: 1 edge.
- Reservation: busy visible the cycle after the accepting edge. Release: busy cleared the cycle after the write edge, or in the same cycle on rd_busy when BYPASS=1.
- Reset asserted mid-reservation discards all pending busy bits; no writeback is required afterwards.
- BYPASS=0: reads and rd_busy reflect registered state only. The core must stall one extra cycle.

## Test plan
- Reset, then dump all registers -> every dump word 0, busy_vec 0, rsv_ok 1. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write 0x12345678 to r5 while rd_addr0=5 (BYPASS=1) -> rd_data0=0x12345678 in the same cycle, and in dump on the next cycle. With BYPASS=0 -> old value 0 in the same cycle.
- trigger=1, write 0xFFFF to r31 -> r31 reads 0x00000001 after 1 edge. trigger=0 -> 0 after 1 edge.
- Reserve r7 -> busy_vec[7]=1 next cycle and rd_busy=1 for a reader of r7. Reserve r7 again -> rsv_ok=0, busy unchanged. Write r7=0xA5 -> busy clears; with BYPASS=1 rd_busy=0 and rd_data=0xA5 during the write cycle.
- r9 busy; same cycle: we to r9 plus rsv_en on r9 -> rsv_ok=1, busy_vec[9] remains 1, r9 holds the written data.
- Reserve r3 and r4, write r3=0x55, assert rst_n=0 for one edge -> all registers 0, busy_vec 0. A write with rst_n=0 has no effect.

Source files
------------

// File: rtl/regfile_sb.sv
// Purpose: parametrised register file with write-to-read bypass, trigger mirror register and per-register busy scoreboard.
// Latency: reads 0 cycles (combinational); writes, reservations and mirror loads take effect at the next rising edge.
// Backpressure: rsv_ok=0 signals a WAW stall on an already-reserved register; writeback is always accepted.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   trigger               level mirrored into register TRIG_IDX
//   rd_addr/rd_data/rd_busy   NRD packed read ports with hazard flag
//   we/wr_addr/wr_data    writeback port (also releases the reservation)
//   rsv_en/rsv_addr/rsv_ok    decode-side destination reservation
//   busy_vec              scoreboard state
//   dump                  registered contents of all registers, no bypass
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int TRIG_IDX = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trigger,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*XLEN-1:0]    rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   rsv_ok,
    output logic [NREGS-1:0]       busy_vec,
    output logic [NREGS*XLEN-1:0]  dump
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] set;
    logic             wr_hit;

    // Register 0 and the trigger mirror can never be written or reserved.
    function automatic logic is_prot(input logic [AW-1:0] a);
        return (a == '0) || ((TRIG_IDX != 0) && (a == AW'(TRIG_IDX)));
    endfunction

    assign wr_hit = we && !is_prot(wr_addr);

    // A writeback in the same cycle releases the register, so a pending
    // reservation on it can be re-granted immediately.
    assign rsv_ok = is_prot(rsv_addr) || !busy[rsv_addr] || (we && (wr_addr == rsv_addr));

    always_comb begin
        clr = '0;
        set = '0;
        if (we) begin
            clr[wr_addr] = 1'b1;
        end
        if (rsv_en && rsv_ok && !is_prot(rsv_addr)) begin
            set[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            // Set applied after clear so a same-cycle re-reservation wins.
            busy <= (busy & ~clr) | set;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (!rst_n || (r == 0)) begin
                regs[r] <= '0;
            end else if ((TRIG_IDX != 0) && (r == TRIG_IDX)) begin
                regs[r] <= {{(XLEN-1){1'b0}}, trigger};
            end else if (we && (wr_addr == AW'(r))) begin
                regs[r] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
            if ((BYPASS != 0) && wr_hit && (wr_addr == rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
                rd_busy[i]              = 1'b0;
            end
        end
    end

    always_comb begin
        dump = '0;
        for (int r = 1; r < NREGS; r++) begin
            dump[r*XLEN +: XLEN] = regs[r];
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int TRIG  = 31;

    logic                  clk;
    logic                  rst_n;
    logic                  trigger;
    logic [NRD*AW-1:0]     rd_addr;
    logic                  we;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;

    // Index 0: BYPASS=0 instance, index 1: BYPASS=1 instance.
    logic [NRD*XLEN-1:0]   rd_data_b0, rd_data_b1;
    logic [NRD-1:0]        rd_busy_b0, rd_busy_b1;
    logic                  rsv_ok_b0, rsv_ok_b1;
    logic [NREGS-1:0]      busy_vec_b0, busy_vec_b1;
    logic [NREGS*XLEN-1:0] dump_b0, dump_b1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: plain arrays updated from the behavioural rules.
    logic [XLEN-1:0]  m_reg [NREGS];
    logic [NREGS-1:0] m_busy;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .TRIG_IDX(TRIG), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .rd_addr(rd_addr),
        .rd_data(rd_data_b0), .rd_busy(rd_busy_b0), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b0),
        .busy_vec(busy_vec_b0), .dump(dump_b0)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .TRIG_IDX(TRIG), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .rd_addr(rd_addr),
        .rd_data(rd_data_b1), .rd_busy(rd_busy_b1), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b1),
        .busy_vec(busy_vec_b1), .dump(dump_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit prot(input logic [AW-1:0] a);
        return (a == 0) || (a == TRIG);
    endfunction

    function automatic logic [AW-1:0] port_addr(input int i);
        logic [NRD*AW-1:0] v;
        v = rd_addr;
        return v[i*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (byp && we && !prot(a) && (wr_addr == a)) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (byp && we && !prot(a) && (wr_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_rsv_ok();
        return prot(rsv_addr) || !m_busy[rsv_addr] || (we && (wr_addr == rsv_addr));
    endfunction

    function automatic logic [NREGS*XLEN-1:0] exp_dump();
        logic [NREGS*XLEN-1:0] d;
        d = '0;
        for (int r = 1; r < NREGS; r++) d[r*XLEN +: XLEN] = m_reg[r];
        return d;
    endfunction

    task automatic chk(input string tag, input logic [NREGS*XLEN-1:0] obs, input logic [NREGS*XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then compare both instances to the model.
    task automatic settle();
        logic [NRD*XLEN-1:0] rdv;
        logic [NRD-1:0]      rbv;
        logic                okv;
        logic [NREGS-1:0]    bv;
        logic [NREGS*XLEN-1:0] dv;
        #1;
        for (int d = 0; d < 2; d++) begin
            rdv = (d == 0) ? rd_data_b0 : rd_data_b1;
            rbv = (d == 0) ? rd_busy_b0 : rd_busy_b1;
            okv = (d == 0) ? rsv_ok_b0 : rsv_ok_b1;
            bv  = (d == 0) ? busy_vec_b0 : busy_vec_b1;
            dv  = (d == 0) ? dump_b0 : dump_b1;
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("b%0d_rd_data%0d", d, i), rdv[i*XLEN +: XLEN], exp_rd(port_addr(i), d == 1));
                chk($sformatf("b%0d_rd_busy%0d", d, i), rbv[i], exp_busy(port_addr(i), d == 1));
            end
            chk($sformatf("b%0d_rsv_ok", d), okv, exp_rsv_ok());
            chk($sformatf("b%0d_busy_vec", d), bv, m_busy);
            chk($sformatf("b%0d_dump", d), dv, exp_dump());
        end
    endtask

    // Clock edge: update the model from the inputs held across the edge.
    task automatic tick();
        logic ok;
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) m_reg[r] = '0;
            m_busy = '0;
        end else begin
            ok = exp_rsv_ok();
            if (we && !prot(wr_addr)) begin
                m_reg[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && ok && !prot(rsv_addr)) m_busy[rsv_addr] = 1'b1;
            m_reg[TRIG] = {{(XLEN-1){1'b0}}, trigger};
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0; trigger = 1'b0; rd_addr = '0;
        idle();
        for (int r = 0; r < NREGS; r++) m_reg[r] = 'x;
        m_busy = 'x;

        // Reset
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst_dump", dump_b1, '0);
        chk("rst_busy_vec", busy_vec_b1, '0);
        chk("rst_rsv_ok", rsv_ok_b1, 1'b1);
        chk("rst_rd_data", rd_data_b1, '0);

        // Write to r0 is dropped
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        settle();
        tick();
        idle();
        settle();
        chk("r0_reads_zero", rd_data_b1[31:0], 32'h0);

        // Bypass of r5
        rd_addr = {5'd0, 5'd5};
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        settle();
        chk("r5_bypass", rd_data_b1[31:0], 32'h12345678);
        chk("r5_nobypass_old", rd_data_b0[31:0], 32'h0);
        tick();
        idle();
        settle();
        chk("r5_dump", dump_b1[5*XLEN +: XLEN], 32'h12345678);

        // Trigger mirror, writeback to it dropped
        trigger = 1'b1; we = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000FFFF;
        rd_addr = {5'd31, 5'd5};
        settle();
        tick();
        idle();
        settle();
        chk("mirror_one", dump_b1[31*XLEN +: XLEN], 32'h1);
        trigger = 1'b0;
        tick();
        settle();
        chk("mirror_zero", dump_b1[31*XLEN +: XLEN], 32'h0);

        // Reserve r7, WAW stall, release by write
        rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr = {5'd5, 5'd7};
        settle();
        tick();
        settle();
        chk("r7_waw_stall", rsv_ok_b1, 1'b0);
        chk("r7_rd_busy", rd_busy_b1[0], 1'b1);
        chk("r7_busy_vec", busy_vec_b1[7], 1'b1);
        tick();
        idle();
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
        settle();
        chk("r7_bypass_busy", rd_busy_b1[0], 1'b0);
        chk("r7_bypass_data", rd_data_b1[31:0], 32'hA5);
        chk("r7_nobypass_busy", rd_busy_b0[0], 1'b1);
        tick();
        idle();
        settle();
        chk("r7_released", busy_vec_b1[7], 1'b0);

        // Same-cycle write + re-reserve on busy r9
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        settle();
        chk("r9_rsv_ok", rsv_ok_b1, 1'b1);
        tick();
        idle();
        settle();
        chk("r9_still_busy", busy_vec_b1[9], 1'b1);
        chk("r9_data", dump_b1[9*XLEN +: XLEN], 32'h99);

        // Reset mid-reservation; write during reset ignored
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_addr = 5'd4;
        tick();
        idle();
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        tick();
        rst_n = 1'b0; wr_addr = 5'd4; wr_data = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd6;
        settle();
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        chk("rst2_dump", dump_b1, '0);
        chk("rst2_busy_vec", busy_vec_b1, '0);

        // Randomized traffic, addresses biased toward a small window for collisions
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            trigger  = 1'($urandom_range(0, 1));
            we       = ($urandom_range(0, 2) != 0);
            rsv_en   = ($urandom_range(0, 1) != 0);
            wr_data  = $urandom;
            wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rsv_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) begin
                rd_addr[i*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            end
            settle();
            tick();
        end

        rst_n = 1'b1;
        idle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
